// File: rtl/otp_shadow_loader.sv
// Boot-time OTP shadow loader: streams NUM_WORDS fuse words into shadow registers
// after reset or reload_req, then acts as a transparent passthrough to the OTP.
module otp_shadow_loader #(
  parameter int          BUS_WIDTH  = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_WORDS  = 4,
  parameter int unsigned BASE_ADDR  = 'h10,
  parameter int          RD_LATENCY = 1,
  parameter int          SDD_BIT    = 0
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [BUS_WIDTH-1:0]            m_ram_raddr,
  input  logic                            m_ram_ren,
  output logic [DATA_WIDTH-1:0]           m_ram_rdata,
  input  logic [BUS_WIDTH-1:0]            m_ram_waddr,
  input  logic [DATA_WIDTH-1:0]           m_ram_wdata,
  input  logic [DATA_WIDTH/8-1:0]         m_ram_wen,
  output logic                            m_ram_busy,
  output logic [BUS_WIDTH-1:0]            s_ram_raddr,
  output logic                            s_ram_ren,
  input  logic [DATA_WIDTH-1:0]           s_ram_rdata,
  output logic [BUS_WIDTH-1:0]            s_ram_waddr,
  output logic [DATA_WIDTH-1:0]           s_ram_wdata,
  output logic [DATA_WIDTH/8-1:0]         s_ram_wen,
  input  logic                            reload_req,
  output logic [NUM_WORDS*DATA_WIDTH-1:0] shadow_data,
  output logic                            load_done,
  output logic                            secure_debug_disable
);

  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int CW = $clog2(NUM_WORDS + 1);
  localparam int BPW = DATA_WIDTH / 8;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {LOAD, DRAIN, DONE} state_t;

  state_t               state_reg, state_next;
  logic [IW-1:0]        idx_reg;
  logic [CW-1:0]        count_reg;
  logic                 pipe_valid_reg [RD_LATENCY];
  logic [IW-1:0]        pipe_idx_reg   [RD_LATENCY];
  logic                 sdd_reg;
  logic                 issue;
  logic                 capture;
  logic                 restart;
  logic [IW-1:0]        cap_idx;
  logic [BUS_WIDTH-1:0] load_addr;

  assign capture   = pipe_valid_reg[RD_LATENCY-1];
  assign cap_idx   = pipe_idx_reg[RD_LATENCY-1];
  assign restart   = (state_reg == DONE) && reload_req;
  assign load_addr = BUS_WIDTH'(BASE_ADDR) + BUS_WIDTH'(idx_reg) * BUS_WIDTH'(BPW);

  assign s_ram_waddr          = m_ram_waddr;
  assign s_ram_wdata          = m_ram_wdata;
  assign load_done            = (state_reg == DONE);
  assign secure_debug_disable = sdd_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= LOAD;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    issue       = 1'b0;
    m_ram_busy  = 1'b1;
    m_ram_rdata = '0;
    s_ram_raddr = load_addr;
    s_ram_ren   = 1'b0;
    s_ram_wen   = '0;
    case (state_reg)
      LOAD: begin
        issue     = 1'b1;
        s_ram_ren = 1'b1;
        if (idx_reg == LAST_IDX) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (capture && (count_reg == LAST_CNT)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        m_ram_busy  = 1'b0;
        m_ram_rdata = s_ram_rdata;
        s_ram_raddr = m_ram_raddr;
        s_ram_ren   = m_ram_ren;
        s_ram_wen   = m_ram_wen;
        if (reload_req) begin
          state_next = LOAD;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx_reg   <= '0;
      count_reg <= '0;
    end else if (restart) begin
      idx_reg   <= '0;
      count_reg <= '0;
    end else begin
      if (issue) begin
        idx_reg <= idx_reg + 1'b1;
      end
      if (capture) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  // Each issued read carries its word index down a RD_LATENCY-deep pipe so the
  // returning OTP data lands in the right shadow word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_valid_reg[i] <= 1'b0;
        pipe_idx_reg[i]   <= '0;
      end
    end else if (restart) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_valid_reg[i] <= 1'b0;
        pipe_idx_reg[i]   <= '0;
      end
    end else begin
      pipe_valid_reg[0] <= issue;
      pipe_idx_reg[0]   <= idx_reg;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_valid_reg[i] <= pipe_valid_reg[i-1];
        pipe_idx_reg[i]   <= pipe_idx_reg[i-1];
      end
    end
  end

  // Sticky: a later reload reading 0 must not re-enable debug.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sdd_reg <= 1'b0;
    end else if (capture && (cap_idx == '0) && s_ram_rdata[SDD_BIT]) begin
      sdd_reg <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_shadow
      logic [DATA_WIDTH-1:0] word_reg;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          word_reg <= '0;
        end else if (capture && (cap_idx == IW'(gi))) begin
          word_reg <= s_ram_rdata;
        end
      end

      assign shadow_data[gi*DATA_WIDTH +: DATA_WIDTH] = word_reg;
    end
  endgenerate

endmodule
